// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types, field offsets and width helper for the trace player
//
// Contents:
//   state_t          replay FSM states
//   DEF_*            default configuration values
//   trace_data_bits  width of one trace ROM entry for a given configuration
//   *_LSB / *_BIT    entry field offsets for the default configuration
//
// Packet entries are laid out MSB first as
// {is_packet, last, [unused], prio, tree_id, meta, data}.
// Idle entries are laid out as {is_packet, last, [unused], count}.
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PUSH  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_PTW        = 16;
    localparam int DEF_MTW        = 16;
    localparam int DEF_TREE_NUM   = 4;
    localparam int DEF_ROM_SIZE   = 8;
    localparam int DEF_IDLECYCLE  = 1024;

    // The two flag bits sit above whichever payload is wider: a packet body
    // or an idle count.
    function automatic int trace_data_bits(input int ptw, input int mtw,
                                           input int tree_num_bits, input int idle_bits);
        int pkt_bits;
        pkt_bits = 2 * ptw + tree_num_bits + mtw;
        return ((idle_bits > pkt_bits) ? idle_bits : pkt_bits) + 2;
    endfunction

    localparam int DEF_TREE_NUM_BITS   = $clog2(DEF_TREE_NUM);
    localparam int DEF_IDLECYCLE_BITS  = $clog2(DEF_IDLECYCLE);
    localparam int DEF_TRACE_DATA_BITS = trace_data_bits(DEF_PTW, DEF_MTW,
                                                         DEF_TREE_NUM_BITS, DEF_IDLECYCLE_BITS);

    localparam int IS_PKT_BIT = DEF_TRACE_DATA_BITS - 1;
    localparam int LAST_BIT   = DEF_TRACE_DATA_BITS - 2;
    localparam int DATA_LSB   = 0;
    localparam int META_LSB   = DATA_LSB + DEF_PTW;
    localparam int TREE_LSB   = META_LSB + DEF_MTW;
    localparam int PRIO_LSB   = TREE_LSB + DEF_TREE_NUM_BITS;

endpackage

// File: rtl/trace_player_if.sv
// rtl/trace_player_if.sv - push request bus from the trace player to the vPIFO
//
// Signals:
//   valid    push request (master -> slave)
//   ready    slave accepts the push (slave -> master)
//   prio     entry priority
//   tree_id  target logical tree
//   meta     metadata
//   data     payload
// A push completes on a cycle where valid and ready are both high.
interface trace_player_if #(
    parameter int PTW           = 16,
    parameter int TREE_NUM_BITS = 2,
    parameter int MTW           = 16
);
    logic                     valid;
    logic                     ready;
    logic [PTW-1:0]           prio;
    logic [TREE_NUM_BITS-1:0] tree_id;
    logic [MTW-1:0]           meta;
    logic [PTW-1:0]           data;

    modport master (output valid, prio, tree_id, meta, data, input ready);
    modport slave  (input valid, prio, tree_id, meta, data, output ready);
endinterface

// File: rtl/trace_entry_decode.sv
// rtl/trace_entry_decode.sv - combinational split of one trace ROM entry into its fields
//
// Ports:
//   entry       raw ROM word
//   is_packet   1 = packet entry, 0 = idle entry
//   last        final entry of the trace
//   idle_count  gap length in cycles (meaningful for idle entries)
//   prio, tree_id, meta, data  packet fields (meaningful for packet entries)
module trace_entry_decode
    import trace_pkg::*;
#(
    parameter int PTW             = 16,
    parameter int MTW             = 16,
    parameter int TREE_NUM_BITS   = 2,
    parameter int IDLECYCLE_BITS  = 10,
    parameter int TRACE_DATA_BITS = trace_data_bits(PTW, MTW, TREE_NUM_BITS, IDLECYCLE_BITS)
) (
    input  logic [TRACE_DATA_BITS-1:0] entry,
    output logic                       is_packet,
    output logic                       last,
    output logic [IDLECYCLE_BITS-1:0]  idle_count,
    output logic [PTW-1:0]             prio,
    output logic [TREE_NUM_BITS-1:0]   tree_id,
    output logic [MTW-1:0]             meta,
    output logic [PTW-1:0]             data
);

    localparam int D_LSB = DATA_LSB;
    localparam int M_LSB = D_LSB + PTW;
    localparam int T_LSB = M_LSB + MTW;
    localparam int P_LSB = T_LSB + TREE_NUM_BITS;

    assign is_packet  = entry[TRACE_DATA_BITS-1];
    assign last       = entry[TRACE_DATA_BITS-2];
    assign idle_count = entry[IDLECYCLE_BITS-1:0];
    assign prio       = entry[P_LSB +: PTW];
    assign tree_id    = entry[T_LSB +: TREE_NUM_BITS];
    assign meta       = entry[M_LSB +: MTW];
    assign data       = entry[D_LSB +: PTW];

endmodule

// File: rtl/trace_player.sv
// rtl/trace_player.sv - replays a stored push trace from ROM into the vPIFO push port
//
// Ports:
//   i_clk, i_arst      clock, asynchronous active-high reset
//   i_start            one-cycle request to begin replay (honoured only in IDLE)
//   i_abort            return to IDLE next cycle, dropping any in-flight push
//   o_rom_read_en      high in FETCH
//   o_rom_addr         current entry pointer; holds its value outside FETCH
//   i_rom_data         ROM word, combinational from o_rom_addr
//   push               push request bus (master side)
//   o_busy             high in FETCH, PUSH and WAIT
//   o_done             one-cycle pulse after the final entry
//   o_push_count       pushes completed in the current replay
module trace_player
    import trace_pkg::*;
#(
    parameter int PTW       = 16,
    parameter int MTW       = 16,
    parameter int TREE_NUM  = 4,
    parameter int ROM_SIZE  = 8,
    parameter int IDLECYCLE = 1024,
    localparam int TREE_NUM_BITS   = $clog2(TREE_NUM),
    localparam int ROM_WIDTH       = $clog2(ROM_SIZE),
    localparam int IDLECYCLE_BITS  = $clog2(IDLECYCLE),
    localparam int TRACE_DATA_BITS = trace_data_bits(PTW, MTW, TREE_NUM_BITS, IDLECYCLE_BITS)
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    input  logic                       i_start,
    input  logic                       i_abort,
    output logic                       o_rom_read_en,
    output logic [ROM_WIDTH-1:0]       o_rom_addr,
    input  logic [TRACE_DATA_BITS-1:0] i_rom_data,
    trace_player_if.master             push,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [ROM_WIDTH:0]         o_push_count
);

    localparam logic [ROM_WIDTH-1:0]      PTR_LAST = ROM_WIDTH'(ROM_SIZE - 1);
    localparam logic [IDLECYCLE_BITS-1:0] CNT_ONE  = IDLECYCLE_BITS'(1);

    logic                      dec_is_packet;
    logic                      dec_last;
    logic [IDLECYCLE_BITS-1:0] dec_idle;
    logic [PTW-1:0]            dec_prio;
    logic [TREE_NUM_BITS-1:0]  dec_tree;
    logic [MTW-1:0]            dec_meta;
    logic [PTW-1:0]            dec_data;

    trace_entry_decode #(
        .PTW             (PTW),
        .MTW             (MTW),
        .TREE_NUM_BITS   (TREE_NUM_BITS),
        .IDLECYCLE_BITS  (IDLECYCLE_BITS),
        .TRACE_DATA_BITS (TRACE_DATA_BITS)
    ) u_decode (
        .entry      (i_rom_data),
        .is_packet  (dec_is_packet),
        .last       (dec_last),
        .idle_count (dec_idle),
        .prio       (dec_prio),
        .tree_id    (dec_tree),
        .meta       (dec_meta),
        .data       (dec_data)
    );

    state_t                    state_q, state_d;
    logic [ROM_WIDTH-1:0]      ptr_q, ptr_d;
    logic [IDLECYCLE_BITS-1:0] cnt_q, cnt_d;
    logic                      last_q, last_d;
    logic [PTW-1:0]            prio_q, prio_d;
    logic [TREE_NUM_BITS-1:0]  tree_q, tree_d;
    logic [MTW-1:0]            meta_q, meta_d;
    logic [PTW-1:0]            data_q, data_d;
    logic [ROM_WIDTH:0]        count_q, count_d;
    logic                      advance;
    logic                      adv_last;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            prio_q  <= '0;
            tree_q  <= '0;
            meta_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            prio_q  <= prio_d;
            tree_q  <= tree_d;
            meta_q  <= meta_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // A zero-length idle entry advances straight out of FETCH, so its last
    // flag comes from the decoder; every other advance uses the flag latched
    // when the entry was fetched.
    assign adv_last = (state_q == ST_FETCH) ? dec_last : last_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        prio_d  = prio_q;
        tree_d  = tree_q;
        meta_d  = meta_q;
        data_d  = data_q;
        count_d = count_q;
        advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            ST_FETCH: begin
                last_d = dec_last;
                if (dec_is_packet) begin
                    prio_d  = dec_prio;
                    tree_d  = dec_tree;
                    meta_d  = dec_meta;
                    data_d  = dec_data;
                    state_d = ST_PUSH;
                end else if (dec_idle != '0) begin
                    cnt_d   = dec_idle;
                    state_d = ST_WAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_PUSH: begin
                if (push.ready) begin
                    count_d = count_q + 1'b1;
                    advance = 1'b1;
                end
            end
            ST_WAIT: begin
                // Counter holds the WAIT cycles still to run, including this one.
                if (cnt_q == CNT_ONE) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // No wrap-around: the final ROM slot ends the trace even without a last flag.
        if (advance) begin
            if (adv_last || (ptr_q == PTR_LAST)) begin
                state_d = ST_DONE;
            end else begin
                ptr_d   = ptr_q + 1'b1;
                state_d = ST_FETCH;
            end
        end

        // Abort wins over everything; a push seen this cycle is not counted and
        // a simultaneous start does not clear the pointer or count.
        if (i_abort) begin
            state_d = ST_IDLE;
            ptr_d   = ptr_q;
            count_d = count_q;
        end
    end

    assign o_rom_read_en = (state_q == ST_FETCH);
    assign o_rom_addr    = ptr_q;
    assign o_busy        = (state_q == ST_FETCH) || (state_q == ST_PUSH) || (state_q == ST_WAIT);
    assign o_done        = (state_q == ST_DONE);
    assign o_push_count  = count_q;

    assign push.valid   = (state_q == ST_PUSH);
    assign push.prio    = prio_q;
    assign push.tree_id = tree_q;
    assign push.meta    = meta_q;
    assign push.data    = data_q;

endmodule

// File: tb/tb_trace_player.sv
// tb/tb_trace_player.sv - self-checking bench for trace_player
module tb_trace_player;
    import trace_pkg::*;

    localparam int T  = 52;
    localparam int PB = 50;

    logic         clk   = 1'b0;
    logic         arst  = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         rd_en;
    logic [2:0]   addr;
    logic [T-1:0] rom_data;
    logic         busy;
    logic         done;
    logic [3:0]   pcnt;
    logic [T-1:0] rom [8];

    trace_player_if #(.PTW(16), .TREE_NUM_BITS(2), .MTW(16)) push ();

    assign rom_data = rom[addr];

    always #5 clk = ~clk;

    trace_player dut (
        .i_clk         (clk),
        .i_arst        (arst),
        .i_start       (start),
        .i_abort       (abort),
        .o_rom_read_en (rd_en),
        .o_rom_addr    (addr),
        .i_rom_data    (rom_data),
        .push          (push),
        .o_busy        (busy),
        .o_done        (done),
        .o_push_count  (pcnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct { int cyc; logic [PB-1:0] f; } push_rec_t;
    typedef struct { int cyc; int a; } fetch_rec_t;

    push_rec_t  obs_push[$];
    push_rec_t  exp_push[$];
    fetch_rec_t obs_fetch[$];
    fetch_rec_t exp_fetch[$];
    int start_cyc = -1;
    int done_cyc  = -1;
    int exp_done  = 0;
    int exp_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start) start_cyc = cyc;
        if (rd_en) obs_fetch.push_back('{cyc, int'(addr)});
        if (push.valid && push.ready)
            obs_push.push_back('{cyc, {push.prio, push.tree_id, push.meta, push.data}});
        if (done) done_cyc = cyc;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [T-1:0] pkt(input bit last, input logic [PB-1:0] f);
        return {1'b1, last, f};
    endfunction

    function automatic logic [T-1:0] idle(input bit last, input int n);
        return {1'b0, last, 40'd0, 10'(n)};
    endfunction

    function automatic logic [PB-1:0] rnd_fields();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PB-1:0];
    endfunction

    // Walk the trace as the spec describes it, with ready always high:
    // a packet costs FETCH + one PUSH cycle, an idle entry costs FETCH + n.
    task automatic build_model();
        int c;
        logic [T-1:0] e;
        c = start_cyc + 1;
        exp_push.delete();
        exp_fetch.delete();
        exp_cnt = 0;
        for (int p = 0; p < 8; p++) begin
            e = rom[p];
            exp_fetch.push_back('{c, p});
            if (e[T-1]) begin
                exp_push.push_back('{c + 1, e[PB-1:0]});
                exp_cnt++;
                c += 2;
            end else begin
                c += 1 + int'(e[9:0]);
            end
            if (e[T-2]) break;
        end
        exp_done = c;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_replay(input string tag);
        int np, nf;
        obs_push.delete();
        obs_fetch.delete();
        done_cyc  = -1;
        start_cyc = -1;
        push.ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 3000 && done_cyc < 0; i++) @(negedge clk);
        check({tag, " done_seen"}, 64'(done_cyc >= 0), 64'd1);
        build_model();
        check({tag, " n_push"}, obs_push.size(), exp_push.size());
        check({tag, " n_fetch"}, obs_fetch.size(), exp_fetch.size());
        np = (obs_push.size() < exp_push.size()) ? obs_push.size() : exp_push.size();
        nf = (obs_fetch.size() < exp_fetch.size()) ? obs_fetch.size() : exp_fetch.size();
        for (int i = 0; i < np; i++) begin
            check($sformatf("%s push%0d cyc", tag, i), obs_push[i].cyc, exp_push[i].cyc);
            check($sformatf("%s push%0d fields", tag, i), obs_push[i].f, exp_push[i].f);
        end
        for (int i = 0; i < nf; i++) begin
            check($sformatf("%s fetch%0d cyc", tag, i), obs_fetch[i].cyc, exp_fetch[i].cyc);
            check($sformatf("%s fetch%0d addr", tag, i), obs_fetch[i].a, exp_fetch[i].a);
        end
        check({tag, " done_cyc"}, done_cyc, exp_done);
        check({tag, " push_count"}, pcnt, exp_cnt);
        @(negedge clk);
        check({tag, " done_pulse_1cyc"}, done, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_en"}, rd_en, 1'b0);
        check({tag, " addr"}, addr, 3'd0);
        check({tag, " valid"}, push.valid, 1'b0);
        check({tag, " fields"}, {push.prio, push.tree_id, push.meta, push.data}, 50'd0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " count"}, pcnt, 4'd0);
    endtask

    initial begin : stim
        logic [PB-1:0] f0;
        push.ready = 1'b0;
        for (int i = 0; i < 8; i++) rom[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 arst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Three packets, last on entry 2
        rom[0] = pkt(0, rnd_fields());
        rom[1] = pkt(0, rnd_fields());
        rom[2] = pkt(1, rnd_fields());
        rom[3] = pkt(0, rnd_fields());
        run_replay("three_pkts");
        check("three_pkts count3", pcnt, 4'd3);
        if (obs_push.size() >= 3) begin
            check("three_pkts spacing01", obs_push[1].cyc - obs_push[0].cyc, 2);
            check("three_pkts spacing12", obs_push[2].cyc - obs_push[1].cyc, 2);
            check("three_pkts done_after_hs", done_cyc - obs_push[2].cyc, 1);
        end

        // Packet, idle 5, packet(last): 6 cycles between handshake and FETCH of entry 2
        rom[0] = pkt(0, rnd_fields());
        rom[1] = idle(0, 5);
        rom[2] = pkt(1, rnd_fields());
        run_replay("idle5");
        if (obs_push.size() >= 1 && obs_fetch.size() >= 3)
            check("idle5 gap", obs_fetch[2].cyc - obs_push[0].cyc - 1, 6);

        // Zero-length idle entry
        rom[0] = pkt(0, rnd_fields());
        rom[1] = idle(0, 0);
        rom[2] = pkt(1, rnd_fields());
        run_replay("idle0");
        if (obs_fetch.size() >= 3)
            check("idle0 back_to_back_fetch", obs_fetch[2].cyc - obs_fetch[1].cyc, 1);

        // No last bit anywhere: ends after slot 7 without wrapping
        for (int i = 0; i < 8; i++)
            rom[i] = (i % 3 == 1) ? idle(0, i) : pkt(0, rnd_fields());
        run_replay("no_last");
        check("no_last addr_held", addr, 3'd7);

        // Randomised traces
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++) begin
                logic [T-1:0] e;
                logic [63:0] r;
                r = {$urandom, $urandom};
                e = r[T-1:0];
                e[T-1] = ($urandom_range(0, 3) != 0);
                e[T-2] = ($urandom_range(0, 6) == 0);
                if (!e[T-1]) e[9:0] = 10'($urandom_range(0, 6));
                rom[i] = e;
            end
            run_replay($sformatf("rand%0d", k));
        end

        // Back-pressure: ready low for 4 PUSH cycles
        push.ready = 1'b0;
        rom[0] = pkt(1, rnd_fields());
        pulse_start();
        for (int i = 0; i < 20 && !push.valid; i++) @(negedge clk);
        f0 = rom[0][PB-1:0];
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall%0d valid", i), push.valid, 1'b1);
            check($sformatf("stall%0d fields", i), {push.prio, push.tree_id, push.meta, push.data}, f0);
            check($sformatf("stall%0d count", i), pcnt, 4'd0);
            if (i < 3) @(negedge clk);
        end
        @(posedge clk); #1 push.ready = 1'b1;
        @(negedge clk);
        check("stall hs valid", push.valid, 1'b1);
        check("stall hs count_before", pcnt, 4'd0);
        @(negedge clk);
        check("stall count_after", pcnt, 4'd1);
        check("stall done", done, 1'b1);
        check("stall valid_low", push.valid, 1'b0);
        @(negedge clk);
        check("stall count_once", pcnt, 4'd1);

        // Abort during WAIT keeps the count
        rom[0] = pkt(0, rnd_fields());
        rom[1] = idle(1, 20);
        push.ready = 1'b1;
        pulse_start();
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("abort pre busy", busy, 1'b1);
        check("abort pre count", pcnt, 4'd1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort busy", busy, 1'b0);
        check("abort valid", push.valid, 1'b0);
        check("abort rd_en", rd_en, 1'b0);
        check("abort count_kept", pcnt, 4'd1);
        @(negedge clk);
        check("abort no_done", done, 1'b0);
        check("abort still_idle", busy, 1'b0);

        // Asynchronous reset during PUSH of a new replay
        rom[0] = pkt(0, rnd_fields());
        rom[1] = pkt(1, rnd_fields());
        push.ready = 1'b1;
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #1 push.ready = 1'b0;
        for (int i = 0; i < 20 && !push.valid; i++) @(negedge clk);
        check("arst pre valid", push.valid, 1'b1);
        check("arst pre count", pcnt, 4'd1);
        check("arst pre addr", addr, 3'd1);
        #1 arst = 1'b1;
        #1;
        check_all_zero("arst");
        @(posedge clk); #1 arst = 1'b0;
        @(negedge clk);
        check_all_zero("arst_release");
        push.ready = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
